// File: rtl/aes128_pkg.sv
// ----------------------------------------------------------------------------
// aes128_pkg
// Shared constants and FSM state type for the AES-128 round key sequencer.
//   AES_KEY_W   : width of one round key
//   AES_NR      : number of AES-128 rounds (NR+1 round keys are stored)
//   AES_ROUND_W : width of a round index
//   rk_state_t  : sequencer FSM states
// ----------------------------------------------------------------------------
package aes128_pkg;

    localparam int unsigned AES_KEY_W   = 128;
    localparam int unsigned AES_NR      = 10;
    localparam int unsigned AES_ROUND_W = 4;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        READY  = 2'd1,
        STREAM = 2'd2
    } rk_state_t;

endpackage : aes128_pkg

// File: rtl/aes128_rk_store.sv
// ----------------------------------------------------------------------------
// aes128_rk_store
// (NR+1) x KEY_W round key register array with a whole-set load enable and a
// round-index read mux.
// Ports:
//   i_clk       : clock
//   i_rst       : asynchronous active-high reset, clears the whole store
//   i_load      : capture all NR+1 keys from i_keys on this edge
//   i_keys      : flattened keys, key i at [i*KEY_W +: KEY_W]
//   i_rd_idx    : round index to read
//   o_rd_key_c  : combinational read data (zero for out-of-range indices)
// ----------------------------------------------------------------------------
module aes128_rk_store
    import aes128_pkg::*;
#(
    parameter int unsigned KEY_W = AES_KEY_W,
    parameter int unsigned NR    = AES_NR
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_load,
    input  logic [KEY_W*(NR+1)-1:0]  i_keys,
    input  logic [AES_ROUND_W-1:0]   i_rd_idx,
    output logic [KEY_W-1:0]         o_rd_key_c
);

    logic [KEY_W-1:0] r_keys [NR+1];

    // Key storage: whole set replaced on load
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i <= NR; i++) begin
                r_keys[i] <= '0;
            end
        end else if (i_load) begin
            for (int unsigned i = 0; i <= NR; i++) begin
                r_keys[i] <= i_keys[i*KEY_W +: KEY_W];
            end
        end
    end

    // Read mux; indices past NR (round field is wider than needed) read as zero
    always_comb begin
        o_rd_key_c = '0;
        if (32'(i_rd_idx) <= NR) begin
            o_rd_key_c = r_keys[i_rd_idx];
        end
    end

endmodule : aes128_rk_store

// File: rtl/aes128_round_key_sequencer.sv
// ----------------------------------------------------------------------------
// aes128_round_key_sequencer
// Registers the NR+1 round keys from the combinational key scheduler on a load
// pulse and serves them one per valid/ready handshake to the iterative round
// datapath. Default order is decryption (round NR first, round 0 last).
// Optional feature macro: AES128_FWD_ORDER_EN adds i_dir (sampled with
// i_start); i_dir=1 selects encryption order (round 0 first, round NR last).
// Ports:
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_key_load      : pulse, capture i_round_keys (aborts a running sequence)
//   i_round_keys    : flattened scheduler outputs, key0 in the LSBs
//   i_start         : pulse, begin one key sequence (only honoured in READY)
//   i_dir           : (AES128_FWD_ORDER_EN only) 1 = encryption order
//   i_rk_ready      : consumer accepts o_rk_data this cycle
//   o_rk_valid      : o_rk_data / o_rk_round valid
//   o_rk_data       : current round key
//   o_rk_round      : round index of o_rk_data
//   o_rk_last       : final key of the sequence
//   o_key_ready     : a key set is stored
//   o_busy          : sequence in progress
// ----------------------------------------------------------------------------
module aes128_round_key_sequencer
    import aes128_pkg::*;
#(
    parameter int unsigned KEY_W = AES_KEY_W,
    parameter int unsigned NR    = AES_NR
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_key_load,
    input  logic [KEY_W*(NR+1)-1:0]  i_round_keys,
    input  logic                     i_start,
`ifdef AES128_FWD_ORDER_EN
    input  logic                     i_dir,
`endif
    input  logic                     i_rk_ready,
    output logic                     o_rk_valid,
    output logic [KEY_W-1:0]         o_rk_data,
    output logic [AES_ROUND_W-1:0]   o_rk_round,
    output logic                     o_rk_last,
    output logic                     o_key_ready,
    output logic                     o_busy
);

    localparam logic [1:0] ST_EMPTY  = 2'(EMPTY);
    localparam logic [1:0] ST_READY  = 2'(READY);
    localparam logic [1:0] ST_STREAM = 2'(STREAM);

    localparam logic [AES_ROUND_W-1:0] RND_FIRST = '0;
    localparam logic [AES_ROUND_W-1:0] RND_LAST  = AES_ROUND_W'(NR);
    localparam logic [AES_ROUND_W-1:0] RND_ONE   = AES_ROUND_W'(1);

    logic [1:0]             r_state;
    logic                   r_valid;
    logic [KEY_W-1:0]       r_data;
    logic [AES_ROUND_W-1:0] r_round;
    logic                   r_last;
    logic                   r_key_ready;
    logic                   r_busy;
    logic                   r_dir;

    logic [1:0]             w_state_nxt;
    logic                   w_valid_nxt;
    logic [AES_ROUND_W-1:0] w_round_nxt;
    logic                   w_last_nxt;
    logic                   w_key_ready_nxt;
    logic                   w_busy_nxt;
    logic                   w_dir_nxt;
    logic                   w_data_upd;
    logic                   w_xfer;
    logic                   w_dir_in;
    logic [AES_ROUND_W-1:0] w_end_round;
    logic [KEY_W-1:0]       w_rd_key;

`ifdef AES128_FWD_ORDER_EN
    assign w_dir_in = i_dir;
`else
    assign w_dir_in = 1'b0;
`endif

    assign w_xfer      = r_valid & i_rk_ready;
    assign w_end_round = r_dir ? RND_LAST : RND_FIRST;

    // Key store, read at the round index that will be presented next cycle
    aes128_rk_store #(
        .KEY_W (KEY_W),
        .NR    (NR)
    ) u_store (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (i_key_load),
        .i_keys     (i_round_keys),
        .i_rd_idx   (w_round_nxt),
        .o_rd_key_c (w_rd_key)
    );

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_EMPTY;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_round     <= '0;
            r_last      <= 1'b0;
            r_key_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_dir       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_valid     <= w_valid_nxt;
            r_round     <= w_round_nxt;
            r_last      <= w_last_nxt;
            r_key_ready <= w_key_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_dir       <= w_dir_nxt;
            if (w_data_upd) begin
                r_data <= w_rd_key;
            end
        end
    end

    // Next-state logic; key_load takes priority over everything, incl. start
    always_comb begin
        w_state_nxt     = r_state;
        w_valid_nxt     = r_valid;
        w_round_nxt     = r_round;
        w_last_nxt      = r_last;
        w_key_ready_nxt = r_key_ready;
        w_busy_nxt      = r_busy;
        w_dir_nxt       = r_dir;
        w_data_upd      = 1'b0;

        if (i_key_load) begin
            w_state_nxt     = ST_READY;
            w_valid_nxt     = 1'b0;
            w_last_nxt      = 1'b0;
            w_busy_nxt      = 1'b0;
            w_key_ready_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                end
                ST_READY: begin
                    if (i_start) begin
                        w_state_nxt = ST_STREAM;
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_dir_nxt   = w_dir_in;
                        w_round_nxt = w_dir_in ? RND_FIRST : RND_LAST;
                        w_last_nxt  = (w_round_nxt == (w_dir_in ? RND_LAST : RND_FIRST));
                        w_data_upd  = 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        if (r_last) begin
                            w_state_nxt = ST_READY;
                            w_valid_nxt = 1'b0;
                            w_busy_nxt  = 1'b0;
                            w_last_nxt  = 1'b0;
                        end else begin
                            // Counter only moves while not at the end value: never wraps
                            w_round_nxt = r_dir ? (r_round + RND_ONE) : (r_round - RND_ONE);
                            w_last_nxt  = (w_round_nxt == w_end_round);
                            w_data_upd  = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    assign o_rk_valid  = r_valid;
    assign o_rk_data   = r_data;
    assign o_rk_round  = r_round;
    assign o_rk_last   = r_last;
    assign o_key_ready = r_key_ready;
    assign o_busy      = r_busy;

endmodule : aes128_round_key_sequencer

// File: tb/tb_aes128_round_key_sequencer.sv
// ----------------------------------------------------------------------------
// tb_aes128_round_key_sequencer
// Scoreboard bench: stimulus pushes the expected key sequence (from a
// behavioural AES-128 key expansion) into a queue; a monitor pops and compares
// on every handshake and checks stability while stalled.
// ----------------------------------------------------------------------------
module tb_aes128_round_key_sequencer;
    import aes128_pkg::*;

    localparam int unsigned KW = AES_KEY_W;
    localparam int unsigned NR = AES_NR;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] data;
        logic         last;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   key_load;
    logic [KW*(NR+1)-1:0]   round_keys;
    logic                   start;
    logic                   rk_ready;
    logic                   rk_valid;
    logic [KW-1:0]          rk_data;
    logic [3:0]             rk_round;
    logic                   rk_last;
    logic                   key_ready;
    logic                   busy;
`ifdef AES128_FWD_ORDER_EN
    logic                   dir;
`endif

    exp_t          q[$];
    logic [127:0]  mk [0:10];
    int            n_checks = 0;
    int            n_errors = 0;
    bit            done = 1'b0;
    bit            mon_hp;
    logic [127:0]  mon_pd;
    logic [3:0]    mon_pr;
    exp_t          mon_e;
    int            cyc;
    int            n;

    always #5 clk = ~clk;

    aes128_round_key_sequencer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_key_load   (key_load),
        .i_round_keys (round_keys),
        .i_start      (start),
`ifdef AES128_FWD_ORDER_EN
        .i_dir        (dir),
`endif
        .i_rk_ready   (rk_ready),
        .o_rk_valid   (rk_valid),
        .o_rk_data    (rk_data),
        .o_rk_round   (rk_round),
        .o_rk_last    (rk_last),
        .o_key_ready  (key_ready),
        .o_busy       (busy)
    );

    // ---------------- reference model: AES-128 key expansion ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] v);
        logic [7:0] inv;
        logic [7:0] b;
        logic [7:0] s;
        inv = 8'h00;
        if (v != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        b = inv;
        s = inv;
        for (int k = 0; k < 4; k++) begin
            b = {b[6:0], b[7]};
            s = s ^ b;
        end
        return s ^ 8'h63;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic random_keys();
        for (int r = 0; r <= 10; r++) mk[r] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drive_keys();
        for (int r = 0; r <= 10; r++) round_keys[r*KW +: KW] = mk[r];
    endtask

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    task automatic check_reset(input string tag);
        cmp({tag, "_valid"},     128'(rk_valid),  128'(0));
        cmp({tag, "_data"},      128'(rk_data),   128'(0));
        cmp({tag, "_round"},     128'(rk_round),  128'(0));
        cmp({tag, "_last"},      128'(rk_last),   128'(0));
        cmp({tag, "_key_ready"}, 128'(key_ready), 128'(0));
        cmp({tag, "_busy"},      128'(busy),      128'(0));
    endtask

    // Expected sequence: rev=0 -> rounds 10..0, rev=1 -> rounds 0..10
    task automatic push_seq(input bit fwd);
        exp_t e;
        for (int i = 0; i <= 10; i++) begin
            e.rnd  = fwd ? 4'(i) : 4'(10 - i);
            e.data = mk[e.rnd];
            e.last = (i == 10);
            q.push_back(e);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_load();
        drive_keys();
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    // Run until the scoreboard is empty; optional illegal start at cycle start_at
    task automatic drain(input bit rnd_ready, input int budget, input int start_at, output int cycles);
        cycles = 0;
        while (q.size() != 0 && cycles < budget) begin
            rk_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = (cycles == start_at);
            tick();
            cycles++;
        end
        start    = 1'b0;
        rk_ready = 1'b0;
        if (q.size() != 0) begin
            fail_now("drain_timeout");
            q.delete();
        end
    endtask

    // ---------------- main ----------------
    initial begin
        rst        = 1'b1;
        key_load   = 1'b0;
        start      = 1'b0;
        rk_ready   = 1'b0;
        round_keys = '0;
`ifdef AES128_FWD_ORDER_EN
        dir        = 1'b0;
`endif
        mon_hp = 1'b0;
        mon_pd = '0;
        mon_pr = '0;

        fork
            // Monitor: handshake scoreboard and stall stability
            begin
                while (!done) begin
                    @(negedge clk);
                    if (rst) begin
                        mon_hp = 1'b0;
                    end else begin
                        if (mon_hp && rk_valid) begin
                            cmp("stall_data",  rk_data, mon_pd);
                            cmp("stall_round", 128'(rk_round), 128'(mon_pr));
                        end
                        if (rk_valid && rk_ready) begin
                            if (q.size() == 0) begin
                                n_checks++;
                                n_errors++;
                                $display("FAIL unexpected_transfer: got round %0d expected none", rk_round);
                            end else begin
                                mon_e = q.pop_front();
                                cmp("xfer_round", 128'(rk_round), 128'(mon_e.rnd));
                                cmp("xfer_data",  rk_data, mon_e.data);
                                cmp("xfer_last",  128'(rk_last), 128'(mon_e.last));
                            end
                        end
                        mon_hp = rk_valid && !rk_ready;
                        mon_pd = rk_data;
                        mon_pr = rk_round;
                    end
                end
            end
            // Stimulus
            begin
                #12;
                check_reset("reset");
                @(negedge clk);
                rst = 1'b0;
                tick();

                // start with no keys stored: ignored
                rk_ready = 1'b1;
                do_start();
                repeat (3) begin
                    cmp("start_empty_valid", 128'(rk_valid), 128'(0));
                    tick();
                end
                cmp("start_empty_busy", 128'(busy), 128'(0));

                // Basic decrypt sequence with FIPS-197 key
                expand_key(128'h000102030405060708090a0b0c0d0e0f);
                do_load();
                cmp("load_key_ready", 128'(key_ready), 128'(1));
                cmp("load_valid",     128'(rk_valid),  128'(0));
                push_seq(1'b0);
                q[0].data  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
                q[9].data  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
                q[10].data = 128'h000102030405060708090a0b0c0d0e0f;
                rk_ready = 1'b1;
                do_start();
                cmp("first_valid", 128'(rk_valid), 128'(1));
                cmp("first_round", 128'(rk_round), 128'(10));
                cmp("first_busy",  128'(busy),     128'(1));
                drain(1'b0, 100, -1, cyc);
                cmp("seq_cycles",  128'(cyc),      128'(11));
                cmp("end_busy",    128'(busy),     128'(0));
                cmp("end_valid",   128'(rk_valid), 128'(0));

                // Backpressure, plus an ignored start during STREAM
                repeat (3) begin
                    push_seq(1'b0);
                    do_start();
                    drain(1'b1, 400, 3, cyc);
                    cmp("bp_end_busy", 128'(busy), 128'(0));
                end

                // Abort at round 5 with a new key set
                push_seq(1'b0);
                rk_ready = 1'b1;
                do_start();
                n = 0;
                while (rk_round != 4'd5 && n < 30) begin
                    tick();
                    n++;
                end
                if (n >= 30) fail_now("abort_wait_round5");
                expand_key({$urandom, $urandom, $urandom, $urandom});
                rk_ready = 1'b0;
                do_load();
                q.delete();
                cmp("abort_valid",     128'(rk_valid),  128'(0));
                cmp("abort_busy",      128'(busy),      128'(0));
                cmp("abort_key_ready", 128'(key_ready), 128'(1));
                push_seq(1'b0);
                do_start();
                cmp("restart_data", rk_data, mk[10]);
                drain(1'b1, 400, -1, cyc);

                // key_load and start together: load wins, no stream
                random_keys();
                drive_keys();
                key_load = 1'b1;
                start    = 1'b1;
                rk_ready = 1'b1;
                tick();
                key_load = 1'b0;
                start    = 1'b0;
                repeat (3) begin
                    cmp("collide_valid", 128'(rk_valid), 128'(0));
                    tick();
                end
                cmp("collide_busy", 128'(busy), 128'(0));
                push_seq(1'b0);
                do_start();
                drain(1'b1, 400, -1, cyc);

                // Asynchronous reset between edges mid-sequence
                push_seq(1'b0);
                rk_ready = 1'b1;
                do_start();
                tick();
                tick();
                #2;
                rst = 1'b1;
                #1;
                check_reset("async_rst");
                q.delete();
                tick();
                rst = 1'b0;
                tick();
                cmp("post_rst_key_ready", 128'(key_ready), 128'(0));
                do_start();
                repeat (2) begin
                    cmp("post_rst_valid", 128'(rk_valid), 128'(0));
                    tick();
                end

`ifdef AES128_FWD_ORDER_EN
                // Encryption order
                expand_key(128'h000102030405060708090a0b0c0d0e0f);
                do_load();
                push_seq(1'b1);
                q[10].data = 128'h13111d7fe3944a17f307a78b4d2b30c5;
                dir = 1'b1;
                rk_ready = 1'b1;
                do_start();
                dir = 1'b0;
                cmp("fwd_first_round", 128'(rk_round), 128'(0));
                cmp("fwd_first_data",  rk_data, 128'h000102030405060708090a0b0c0d0e0f);
                drain(1'b1, 400, -1, cyc);
                cmp("fwd_end_busy", 128'(busy), 128'(0));
`endif
                rk_ready = 1'b0;
                tick();
                done = 1'b1;
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_aes128_round_key_sequencer
